mc_alu_muldiv: RTL and testbench
================================

Name: mc_alu_muldiv

Overview:
Parametrised successor of the single-cycle ALU for the multi-cycle and pipelined MIPS cores.
- Keeps the combinational logic and arithmetic operations with zero and overflow flags, generalised to WIDTH bits.
- Adds SLT, NOR and XOR.
- Adds an iterative signed/unsigned multiply/divide unit with HI/LO registers and a start/busy/done handshake, used by the control unit to stall on MFHI/MFLO.

Parameters:
WIDTH, 32, datapath width in bits (>= 8).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
op1  input  WIDTH  operand A (rs)
op2  input  WIDTH  operand B (rt/immediate)
alu_control  input  4  operation select
start  input  1  launch mul/div when alu_control is a mul/div code
res  output  WIDTH  combinational result
zero  output  1  res == 0
overflow  output  1  signed overflow for ADD/SUB
busy  output  1  mul/div in progress
done  output  1  one-cycle pulse: HI/LO just updated
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- alu_control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 XOR
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU
  - 1110 MFHI, 1111 MFLO
  - Any other code: res = 0.
- Combinational path, no latency:
  - ADD overflow = operands same sign, result sign differs.
  - SUB overflow = operands differ in sign, result sign equals op2 sign.
  - overflow = 0 for every other code.
  - SLT: signed compare; res = 1 if op1 < op2, else 0.
  - MFHI/MFLO: res = hi/lo. No interlock; the current register value is returned even while busy.
  - Mul/div codes: res = 0.
  - zero is derived from res for every code.
- Reset: state IDLE, busy = 0, done = 0, hi = 0, lo = 0, internal counter and shadow registers = 0.
- State machine: IDLE -> RUN -> FIN -> IDLE.
  - IDLE:
    - Transition: start=1 with a mul/div code moves to RUN at the clock edge.
    - On that edge: latch operand magnitudes, the op kind and the result-sign flags; clear the counter.
    - Ignored: start with a non-mul/div code, or a mul/div code with start=0.
  - RUN:
    - busy = 1.
    - One radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
    - Exactly WIDTH cycles, counter 0..WIDTH-1, then FIN.
    - start is ignored; a new operation is not queued.
  - FIN:
    - busy = 0, done = 1 for exactly one cycle.
    - hi/lo are written on the edge entering FIN, so they are valid while done = 1.
    - Unconditional return to IDLE. start is ignored in FIN.
- Timing: start sampled at the end of cycle 0; RUN in cycles 1..WIDTH; done in cycle WIDTH+1. Minimum spacing between starts is WIDTH+2 cycles.
- MULT/MULTU result: {hi, lo} = 2*WIDTH-bit product. MULT negates the product when the operand signs differ.
- DIV/DIVU result: lo = quotient (truncated toward zero), hi = remainder.
  - Remainder takes the sign of the dividend.
  - Quotient is negated when the signs differ.
- Divide by zero (signed or unsigned): lo = all ones, hi = op1 as latched. No exception; completes in the normal WIDTH+1 cycles.
- Signed DIV of most-negative by -1: lo = most-negative value, hi = 0.
- hi/lo change only on the edge entering FIN, or on reset.
- rst asserted mid-operation: immediate abort to IDLE; busy, done, hi and lo go to 0; no done pulse follows.
- Operand inputs may change after the start cycle without affecting the running operation.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> res 0x80000000, overflow 1, zero 0. SUB 5 - 5 -> res 0, zero 1, overflow 0. SLT 0xFFFFFFFF vs 1 -> res 1.
- MULT op1 = 0xFFFFFFFD (-3), op2 = 5, start in cycle 0 -> busy cycles 1..32, done only in cycle 33, hi 0xFFFFFFFF, lo 0xFFFFFFF1. MULTU 0xFFFFFFFF * 2 -> hi 0x00000001, lo 0xFFFFFFFE.
- DIVU 100 / 7 -> lo 14, hi 2. DIV -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo 0x80000000, hi 0.
- DIVU 0x1234 / 0 -> lo 0xFFFFFFFF, hi 0x00001234, done in cycle 33.
- During a MULT: start pulsed in cycles 5 and 33 with DIVU codes -> both ignored. MFLO in cycle 10 returns the previous lo. rst asserted in cycle 10 -> busy 0, hi = lo = 0 immediately, no done pulse.
- WIDTH=8 build: MULT 0x80 * 0x80 -> done in cycle 9, hi 0x40, lo 0x00. ADD 0x7F + 0x01 -> overflow 1.

Source files
------------

// File: rtl/mc_alu_muldiv.sv
// mc_alu_muldiv: combinational ALU (logic, add/sub with overflow, SLT, NOR,
// XOR, MFHI/MFLO) plus an iterative radix-2 multiply/divide unit that owns
// the HI/LO registers. The multiply uses shift-add and the divide uses
// restoring shift-subtract. Both share one accumulator/quotient register
// pair and take WIDTH RUN cycles.
//
// Handshake: a mul/div code with start=1 is accepted only in IDLE, at the
// rising edge. busy is high for the WIDTH cycles of RUN. done is a one-cycle
// pulse in FIN, during which hi/lo already hold the new result. start is
// ignored outside IDLE, and nothing is queued.
module mc_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_control,
    input  logic             start,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       o_dbg_state
);
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_XOR  = 4'b1101;
    localparam logic [3:0] C_MFHI = 4'b1110;
    localparam logic [3:0] C_MFLO = 4'b1111;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_acc, r_q, r_b, r_hi, r_lo;
    logic             r_is_div, r_neg_q, r_neg_r, r_div0;
    logic [CW-1:0]    r_cnt;

    // Mul/div codes are 10xx; bit0 = unsigned, bit1 = divide.
    logic w_is_md, w_signed_op, w_launch, w_last;
    assign w_is_md     = (alu_control[3:2] == 2'b10);
    assign w_signed_op = ~alu_control[0];
    assign w_launch    = start & w_is_md;
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    assign w_a_mag = (w_signed_op && op1[WIDTH-1]) ? -op1 : op1;
    assign w_b_mag = (w_signed_op && op2[WIDTH-1]) ? -op2 : op2;

    // One radix-2 step: multiplier bits retire from r_q's LSB; dividend bits
    // leave r_q's MSB while quotient bits enter at its LSB.
    logic [WIDTH:0]     w_madd, w_shift, w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_acc_nx, w_q_nx, w_quo, w_rem, w_hi_fin, w_lo_fin;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    assign w_madd   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_shift  = {r_acc, r_q[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_b};
    assign w_ge     = ~w_trial[WIDTH];
    assign w_acc_nx = r_is_div ? (w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0])
                               : w_madd[WIDTH:1];
    assign w_q_nx   = r_is_div ? {r_q[WIDTH-2:0], w_ge} : {w_madd[0], r_q[WIDTH-1:1]};

    // Sign fix-up of the final step. Divide-by-zero leaves the dividend
    // magnitude in the remainder, so hi naturally becomes op1 after the sign fix.
    assign w_prod   = {w_acc_nx, w_q_nx};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -w_q_nx : w_q_nx);
    assign w_rem    = r_neg_r ? -w_acc_nx : w_acc_nx;
    assign w_hi_fin = r_is_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
    assign w_lo_fin = r_is_div ? w_quo : w_prod_s[WIDTH-1:0];

    // Combinational ALU result and signed overflow
    logic [WIDTH-1:0] w_sum, w_diff;
    assign w_sum  = op1 + op2;
    assign w_diff = op1 - op2;
    always_comb begin
        res      = '0;
        overflow = 1'b0;
        case (alu_control)
            C_AND:  res = op1 & op2;
            C_OR:   res = op1 | op2;
            C_ADD: begin
                res      = w_sum;
                overflow = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            C_SUB: begin
                res      = w_diff;
                overflow = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_diff[WIDTH-1] == op2[WIDTH-1]);
            end
            C_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            C_NOR:  res = ~(op1 | op2);
            C_XOR:  res = op1 ^ op2;
            C_MFHI: res = r_hi;
            C_MFLO: res = r_lo;
            default: res = '0;
        endcase
    end
    assign zero = (res == '0);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nx = S_RUN;
            S_RUN:   if (w_last)   w_state_nx = S_FIN;
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy        = (r_state == S_RUN);
        done        = (r_state == S_FIN);
        o_dbg_state = r_state;
    end

    // Mul/div datapath: latch on launch, iterate in RUN, commit hi/lo on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (r_state == S_IDLE && w_launch) begin
            r_acc    <= '0;
            r_q      <= w_a_mag;
            r_b      <= w_b_mag;
            r_cnt    <= '0;
            r_is_div <= alu_control[1];
            r_neg_q  <= w_signed_op & (op1[WIDTH-1] ^ op2[WIDTH-1]);
            r_neg_r  <= w_signed_op & alu_control[1] & op1[WIDTH-1];
            r_div0   <= alu_control[1] & (op2 == '0);
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_hi <= w_hi_fin;
                r_lo <= w_lo_fin;
            end
        end
    end
endmodule

// File: tb/tb_mc_alu_muldiv.sv
// Self-checking bench for mc_alu_muldiv: directed cases plus randomized ALU
// and mul/div traffic against an arithmetic reference model; a second
// WIDTH=8 instance covers the narrow build.
module tb_mc_alu_muldiv;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] op1, op2, res, hi, lo;
  logic [3:0]   ctl;
  logic         start, zero, overflow, busy, done;
  logic [1:0]   dbg;

  logic [7:0]   op1_8, op2_8, res_8, hi_8, lo_8;
  logic [3:0]   ctl_8;
  logic         start_8, zero_8, overflow_8, busy_8, done_8;
  logic [1:0]   dbg_8;

  mc_alu_muldiv #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .op1(op1), .op2(op2), .alu_control(ctl), .start(start),
    .res(res), .zero(zero), .overflow(overflow), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .o_dbg_state(dbg)
  );

  mc_alu_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .op1(op1_8), .op2(op2_8), .alu_control(ctl_8), .start(start_8),
    .res(res_8), .zero(zero_8), .overflow(overflow_8), .busy(busy_8), .done(done_8),
    .hi(hi_8), .lo(lo_8), .o_dbg_state(dbg_8)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_res(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1101: return a ^ b;
      4'b1110: return m_hi;
      4'b1111: return m_lo;
      default: return '0;
    endcase
  endfunction

  // Overflow = the true signed result does not fit in 32 bits.
  function automatic logic model_ovf(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    if (c == 4'b0010)      s = longint'($signed(a)) + longint'($signed(b));
    else if (c == 4'b0110) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic void model_md(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    h = '0;
    l = '0;
    case (c)
      4'b1000: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h = sp[63:32];
        l = sp[31:0];
      end
      4'b1001: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32];
        l = up[31:0];
      end
      4'b1010: begin
        if (b == 0) begin
          l = '1;
          h = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = '0;
        end else begin
          sa = a;
          sb = b;
          l = sa / sb;
          h = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          l = '1;
          h = a;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic alu_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e;
    @(negedge clk);
    ctl = c; op1 = a; op2 = b; start = 1'b0;
    #1;
    e = model_res(c, a, b);
    check("alu_res", res, e);
    check("alu_zero", zero, (e == 0));
    check("alu_ovf", overflow, model_ovf(c, a, b));
  endtask

  // Launch in cycle 0, then check busy/done per cycle through cycle W+2.
  // With disturb set: DIVU start pulses in cycles 5 and W+1, MFLO read in cycle 10.
  task automatic md_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    logic [W-1:0] eh, el;
    logic [1:0] idle_dbg;
    model_md(c, a, b, eh, el);
    @(negedge clk);
    idle_dbg = dbg;
    ctl = c; op1 = a; op2 = b; start = 1'b1;
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      ctl = 4'($urandom_range(0, 15));
      op1 = $urandom();
      op2 = $urandom();
      if (disturb && (cyc == 5 || cyc == W + 1)) begin
        start = 1'b1;
        ctl = 4'b1011;
      end
      if (disturb && cyc == 10) begin
        ctl = 4'b1111;
        #1;
        check("mflo_while_busy", res, m_lo);
      end
      if (cyc <= W) begin
        check("busy_run", busy, 1'b1);
        check("done_run", done, 1'b0);
        if (cyc == 1) check("dbg_run_vs_idle", (dbg != idle_dbg), 1'b1);
        if (cyc == W) begin
          check("hi_hold", hi, m_hi);
          check("lo_hold", lo, m_lo);
        end
      end else if (cyc == W + 1) begin
        check("busy_fin", busy, 1'b0);
        check("done_fin", done, 1'b1);
        check("hi_result", hi, eh);
        check("lo_result", lo, el);
      end else begin
        check("busy_after", busy, 1'b0);
        check("done_after", done, 1'b0);
      end
    end
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic abort_test();
    bit saw_done;
    @(negedge clk);
    ctl = 4'b1000; op1 = 32'h1234_5678; op2 = 32'h0000_0777; start = 1'b1;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    check("busy_pre_abort", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_abort", saw_done, 1'b0);
    check("lo_after_abort", lo, 32'd0);
  endtask

  task automatic narrow_test();
    logic [1:0] idle_dbg;
    @(negedge clk);
    ctl_8 = 4'b0010; op1_8 = 8'h7F; op2_8 = 8'h01; start_8 = 1'b0;
    #1;
    check("w8_add_res", res_8, 8'h80);
    check("w8_add_ovf", overflow_8, 1'b1);
    check("w8_add_zero", zero_8, 1'b0);
    idle_dbg = dbg_8;
    @(negedge clk);
    ctl_8 = 4'b1000; op1_8 = 8'h80; op2_8 = 8'h80; start_8 = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start_8 = 1'b0;
      ctl_8 = 4'b0000;
      if (cyc == 1) check("w8_dbg_run_vs_idle", (dbg_8 != idle_dbg), 1'b1);
      if (cyc <= 8) begin
        check("w8_busy", busy_8, 1'b1);
        check("w8_done_early", done_8, 1'b0);
      end else if (cyc == 9) begin
        check("w8_done", done_8, 1'b1);
        check("w8_hi", hi_8, 8'h40);
        check("w8_lo", lo_8, 8'h00);
      end else begin
        check("w8_done_after", done_8, 1'b0);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    op1 = '0; op2 = '0; ctl = '0; start = 1'b0;
    op1_8 = '0; op2_8 = '0; ctl_8 = '0; start_8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b0;

    // Directed ALU cases
    alu_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_ovf_const", overflow, 1'b1);
    alu_op(4'b0110, 32'd5, 32'd5);
    check("sub_zero_const", zero, 1'b1);
    alu_op(4'b0111, 32'hFFFF_FFFF, 32'd1);
    check("slt_const", res, 32'd1);
    alu_op(4'b0110, 32'h8000_0000, 32'h0000_0001);
    alu_op(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678);

    // Directed mul/div cases
    md_op(4'b1000, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFF1);
    md_op(4'b1001, 32'hFFFF_FFFF, 32'd2, 1'b0);
    md_op(4'b1011, 32'd100, 32'd7, 1'b0);
    check("divu_lo_const", lo, 32'd14);
    check("divu_hi_const", hi, 32'd2);
    md_op(4'b1010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    md_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    md_op(4'b1011, 32'h0000_1234, 32'd0, 1'b0);
    check("divu0_hi_const", hi, 32'h0000_1234);
    md_op(4'b1010, 32'hFFFF_FF00, 32'd0, 1'b0);
    md_op(4'b1000, 32'h0001_2345, 32'hFFFE_0001, 1'b1);
    alu_op(4'b1110, 32'd0, 32'd0);
    alu_op(4'b1111, 32'd0, 32'd0);

    // Randomized mul/div traffic with MFHI/MFLO readback
    for (int i = 0; i < 20; i++) begin
      md_op(4'b1000 + 4'($urandom_range(0, 3)), pick_op(), pick_op(), 1'($urandom_range(0, 1)));
      alu_op(4'b1110, $urandom(), $urandom());
      alu_op(4'b1111, $urandom(), $urandom());
    end

    // Randomized ALU traffic over all codes
    for (int i = 0; i < 60; i++) begin
      alu_op(4'($urandom_range(0, 15)), pick_op(), pick_op());
    end

    abort_test();
    narrow_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
